pagerank_iteration_ctrl: RTL and testbench
==========================================

Name: pagerank_iteration_ctrl

Overview:
- Sequences complete PageRank iterations around the scatter engine and `pagerank_local_update`.
- Per iteration, in order:
  - clear the partial sums (pulse `nextIteration`);
  - launch scatter;
  - wait for scatter and gather completion;
  - walk every node ID through the downstream damping/apply stage with a valid/ready handshake.
- Repeats for a programmed number of iterations, then signals done. Sits at top level as the single owner of `pagerank_enable` and `nextIteration`.

Parameters:
- `NODES_IN_GRAPH`, 4, number of node IDs walked in the APPLY phase (≥1).
- `ITER_W`, 8, width of the iteration count/target.
- `WATCHDOG_CYCLES`, 1024, max cycles allowed in SCATTER+GATHER per iteration (used only with `PAGERANK_WATCHDOG_EN`).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `num_iterations`  in  `ITER_W`  iteration target, latched when `start` is accepted; 0 is treated as 1.
- `scatter_operation_complete`  in  1  level from scatter engine: stream finished.
- `gather_operation_complete`  in  1  level from local update: accumulation finished.
- `apply_ready`  in  1  damping stage accepts the current `apply_node_id`.
- `scatter_start`  out  1  one-cycle pulse launching the scatter engine.
- `nextIteration`  out  1  one-cycle pulse clearing the local-update sums.
- `pagerank_enable`  out  1  high in SCATTER and GATHER only.
- `apply_valid`  out  1  high in APPLY.
- `apply_node_id`  out  32  node ID presented to the damping stage.
- `iteration_count`  out  `ITER_W`  number of completed iterations in the current run.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the run ends.
- `watchdog_error`  out  1  sticky error flag (see Optional Feature).

Behaviour:
- All outputs are registered. Reset (asynchronous, any time, including mid-run):
  - state returns to IDLE;
  - every output is cleared to 0, including `iteration_count` and `apply_node_id`;
  - the latched target is cleared.
  - No partial iteration resumes after reset.
- States: IDLE, CLEAR, SCATTER, GATHER, APPLY, CHECK, FINISH.
- IDLE:
  - `start` high → latch target (`max(num_iterations,1)`), clear `iteration_count`, go to CLEAR.
  - `start` in any other state is ignored.
- CLEAR: one cycle with `nextIteration`=1 → SCATTER.
- SCATTER:
  - `scatter_start`=1 on the first cycle only; `pagerank_enable`=1.
  - `scatter_operation_complete` → GATHER.
  - If `gather_operation_complete` is also high in the same cycle → APPLY directly.
- GATHER: `pagerank_enable`=1; `gather_operation_complete` → APPLY, with `apply_node_id`=0.
- APPLY:
  - `apply_valid`=1; `apply_node_id` is held stable until `apply_valid && apply_ready`.
  - On handshake with `apply_node_id` = `NODES_IN_GRAPH`-1 → CHECK; otherwise increment the ID.
  - Exactly `NODES_IN_GRAPH` handshakes per iteration; `apply_ready` may stall indefinitely.
- CHECK:
  - one cycle; `iteration_count` += 1.
  - If the new count equals the target → FINISH, else → CLEAR.
- FINISH: `done`=1 for one cycle → IDLE. `iteration_count` holds its final value until the next accepted `start`.
- Latency, no stalls, per iteration: 1 (CLEAR) + scatter cycles + gather cycles + `NODES_IN_GRAPH` (APPLY) + 1 (CHECK).
- Counter widths: `apply_node_id` is compared at `NODES_IN_GRAPH`-1 and never wraps. `iteration_count` cannot overflow because target ≤ 2^`ITER_W`-1.

Optional Feature:
- Macro `PAGERANK_WATCHDOG_EN`.
- Defined:
  - a cycle counter starts in CLEAR and counts every SCATTER/GATHER cycle.
  - On reaching `WATCHDOG_CYCLES` → `watchdog_error`=1 (sticky), go to FINISH (`done` pulses), and `iteration_count` is not incremented.
  - `watchdog_error` clears only on reset or the next accepted `start`.
- Undefined: no counter logic; `watchdog_error` is tied to 0; SCATTER/GATHER wait indefinitely.

Test Plan:
- Reset mid-APPLY at node 2 → all outputs 0 in the same cycle, state IDLE; a new `start` runs cleanly from `iteration_count`=0.
- `num_iterations`=2, scatter complete 5 cycles after `scatter_start`, gather 2 cycles later, `apply_ready`=1 → exactly 2 `nextIteration` and 2 `scatter_start` pulses, `apply_node_id` 0,1,2,3 twice, `done` pulse, `iteration_count`=2.
- `num_iterations`=0 → behaves as 1: a single iteration, `iteration_count`=1, one `done` pulse.
- `apply_ready` low for 3 cycles on node 1 → `apply_node_id` held at 1 with `apply_valid`=1; the sequence continues 2,3 after ready rises; `start` pulsed during the run is ignored.
- Scatter and gather complete in the same SCATTER cycle → next state APPLY (GATHER skipped), `pagerank_enable` drops.
- With `PAGERANK_WATCHDOG_EN`, `WATCHDOG_CYCLES`=16, scatter complete never asserted → `watchdog_error`=1, `done` pulse, `iteration_count`=0.
- Without the macro, the same stimulus → `busy` stays 1 and `watchdog_error`=0.

Source files
------------

// File: rtl/pagerank_iteration_ctrl.sv
// pagerank_iteration_ctrl: sequences complete PageRank iterations
// (clear sums -> scatter -> gather -> apply walk -> check) for a programmed
// number of iterations, then pulses done.
// Optional SCATTER/GATHER watchdog: compile with `define PAGERANK_WATCHDOG_EN.
module pagerank_iteration_ctrl #(
  parameter int NODES_IN_GRAPH  = 4,
  parameter int ITER_W          = 8,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ITER_W-1:0] num_iterations,
  input  logic              scatter_operation_complete,
  input  logic              gather_operation_complete,
  input  logic              apply_ready,
  output logic              scatter_start,
  output logic              nextIteration,
  output logic              pagerank_enable,
  output logic              apply_valid,
  output logic [31:0]       apply_node_id,
  output logic [ITER_W-1:0] iteration_count,
  output logic              busy,
  output logic              done,
  output logic              watchdog_error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    SCATTER = 3'd2,
    GATHER  = 3'd3,
    APPLY   = 3'd4,
    CHECK   = 3'd5,
    FINISH  = 3'd6
  } state_t;

  localparam logic [31:0] LAST_NODE = 32'(NODES_IN_GRAPH - 1);

  state_t            state;
  state_t            state_next;
  logic [ITER_W-1:0] target;
  logic [ITER_W-1:0] target_next;
  logic [ITER_W-1:0] count_next;
  logic [31:0]       node_next;
  logic              accept_start;
  logic              wd_fire;

  assign accept_start = (state == IDLE) && start;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus next values of target, iteration count and node ID
  always_comb begin
    state_next  = state;
    target_next = target;
    count_next  = iteration_count;
    node_next   = apply_node_id;
    unique case (state)
      IDLE: begin
        if (accept_start) begin
          // A target of zero is run as a single iteration
          target_next = (num_iterations == '0) ? ITER_W'(1) : num_iterations;
          count_next  = '0;
          state_next  = CLEAR;
        end
      end
      CLEAR: state_next = SCATTER;
      SCATTER: begin
        if (wd_fire) begin
          state_next = FINISH;
        end else if (scatter_operation_complete) begin
          if (gather_operation_complete) begin
            // Gather already finished too: skip straight to the apply walk
            state_next = APPLY;
            node_next  = '0;
          end else begin
            state_next = GATHER;
          end
        end
      end
      GATHER: begin
        if (wd_fire) begin
          state_next = FINISH;
        end else if (gather_operation_complete) begin
          state_next = APPLY;
          node_next  = '0;
        end
      end
      APPLY: begin
        if (apply_ready) begin
          if (apply_node_id == LAST_NODE) begin
            state_next = CHECK;
            count_next = iteration_count + 1'b1;
          end else begin
            node_next = apply_node_id + 32'd1;
          end
        end
      end
      CHECK:   state_next = (iteration_count == target) ? FINISH : CLEAR;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs, decoded from the state being entered so they line up with it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      target          <= '0;
      iteration_count <= '0;
      apply_node_id   <= '0;
      nextIteration   <= 1'b0;
      scatter_start   <= 1'b0;
      pagerank_enable <= 1'b0;
      apply_valid     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      target          <= target_next;
      iteration_count <= count_next;
      apply_node_id   <= node_next;
      nextIteration   <= (state_next == CLEAR);
      scatter_start   <= (state_next == SCATTER) && (state != SCATTER);
      pagerank_enable <= (state_next == SCATTER) || (state_next == GATHER);
      apply_valid     <= (state_next == APPLY);
      busy            <= (state_next != IDLE);
      done            <= (state_next == FINISH);
    end
  end

`ifdef PAGERANK_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES) + 1;

  logic [WD_W-1:0] wd_count;

  // Fires on the last allowed SCATTER/GATHER cycle of the iteration
  assign wd_fire = ((state == SCATTER) || (state == GATHER)) &&
                   (wd_count == WD_W'(WATCHDOG_CYCLES - 1));

  // Cycle counter: restarts in CLEAR, advances on every SCATTER/GATHER cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_count <= '0;
    end else if (state == CLEAR) begin
      wd_count <= '0;
    end else if ((state == SCATTER) || (state == GATHER)) begin
      wd_count <= wd_count + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset or the next accepted start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      watchdog_error <= 1'b0;
    end else if (accept_start) begin
      watchdog_error <= 1'b0;
    end else if (wd_fire) begin
      watchdog_error <= 1'b1;
    end
  end
`else
  assign wd_fire        = 1'b0;
  assign watchdog_error = 1'b0;
`endif

endmodule

// File: tb/tb_pagerank_iteration_ctrl.sv
// tb_pagerank_iteration_ctrl: randomized and directed runs of the iteration
// controller, checked against an event-timing model of the iteration sequence.
module tb_pagerank_iteration_ctrl;

  localparam int NODES     = 4;
  localparam int ITER_W    = 8;
  localparam int WD_CYCLES = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ITER_W-1:0] num_iterations = '0;
  logic              scatter_operation_complete = 1'b0;
  logic              gather_operation_complete = 1'b0;
  logic              apply_ready = 1'b0;
  logic              scatter_start;
  logic              nextIteration;
  logic              pagerank_enable;
  logic              apply_valid;
  logic [31:0]       apply_node_id;
  logic [ITER_W-1:0] iteration_count;
  logic              busy;
  logic              done;
  logic              watchdog_error;

  int vec_count = 0;
  int err_count = 0;

  pagerank_iteration_ctrl #(
    .NODES_IN_GRAPH (NODES),
    .ITER_W         (ITER_W),
    .WATCHDOG_CYCLES(WD_CYCLES)
  ) dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .start                     (start),
    .num_iterations            (num_iterations),
    .scatter_operation_complete(scatter_operation_complete),
    .gather_operation_complete (gather_operation_complete),
    .apply_ready               (apply_ready),
    .scatter_start             (scatter_start),
    .nextIteration             (nextIteration),
    .pagerank_enable           (pagerank_enable),
    .apply_valid               (apply_valid),
    .apply_node_id             (apply_node_id),
    .iteration_count           (iteration_count),
    .busy                      (busy),
    .done                      (done),
    .watchdog_error            (watchdog_error)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_scatter_start"}, 32'(scatter_start), 0);
    check_val({tag, "_next_iter"},     32'(nextIteration), 0);
    check_val({tag, "_enable"},        32'(pagerank_enable), 0);
    check_val({tag, "_apply_valid"},   32'(apply_valid), 0);
    check_val({tag, "_node_id"},       apply_node_id, 0);
    check_val({tag, "_iter_count"},    32'(iteration_count), 0);
    check_val({tag, "_busy"},          32'(busy), 0);
    check_val({tag, "_done"},          32'(done), 0);
    check_val({tag, "_wd_error"},      32'(watchdog_error), 0);
  endtask

  // One complete run. The bench plays the scatter engine (complete s_lat cycles
  // after scatter_start) and the local update (complete g_lat cycles after that).
  // mode 0: always ready; 1: random ready and stray starts; 2: ready low for 3
  // cycles on node 1 with start asserted while stalled.
  task automatic run(input int n_iter, input int s_lat, input int g_lat, input int mode);
    int exp_iters, n_clear, n_ss, n_done, iters_done, node_exp;
    int ss_cyc, apply_at, clear_cyc, last_hs, stall_left, cyc;
    bit apply_on, finished;
    exp_iters  = (n_iter == 0) ? 1 : n_iter;
    n_clear    = 0;
    n_ss       = 0;
    n_done     = 0;
    iters_done = 0;
    node_exp   = 0;
    ss_cyc     = -1;
    apply_at   = -1;
    clear_cyc  = -1;
    last_hs    = -1;
    stall_left = (mode == 2) ? 3 : 0;
    apply_on   = 1'b0;
    finished   = 1'b0;
    cyc        = 0;
    check_val("idle_busy", 32'(busy), 0);
    scatter_operation_complete = 1'b0;
    gather_operation_complete  = 1'b0;
    apply_ready    = 1'b1;
    start          = 1'b1;
    num_iterations = ITER_W'(n_iter);
    tick();
    start = 1'b0;
    for (cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (nextIteration) begin
        n_clear++;
        check_val("clear_time", 32'(cyc), 32'((last_hs < 0) ? 0 : last_hs + 2));
        clear_cyc = cyc;
        ss_cyc    = -1;
        apply_at  = -1;
      end
      if (scatter_start) begin
        n_ss++;
        check_val("scatter_time", 32'(cyc), 32'(clear_cyc + 1));
        ss_cyc   = cyc;
        apply_at = cyc + s_lat + g_lat + 1;
      end
      if (apply_at >= 0 && cyc == apply_at) apply_on = 1'b1;
      check_val("enable", 32'(pagerank_enable), 32'(ss_cyc >= 0 && cyc <= ss_cyc + s_lat + g_lat));
      check_val("apply_valid", 32'(apply_valid), 32'(apply_on));
      check_val("busy", 32'(busy), 1);
      check_val("iter_count", 32'(iteration_count), 32'(iters_done));
      if (apply_on) check_val("node_id", apply_node_id, 32'(node_exp));
      if (done) begin
        n_done++;
        check_val("done_time", 32'(cyc), 32'(last_hs + 2));
        finished = 1'b1;
      end
      // Inputs for the current cycle
      scatter_operation_complete = (ss_cyc >= 0) && (cyc >= ss_cyc + s_lat);
      gather_operation_complete  = (ss_cyc >= 0) && (cyc >= ss_cyc + s_lat + g_lat);
      if (mode == 0) begin
        apply_ready = 1'b1;
        start       = 1'b0;
      end else if (mode == 2) begin
        if (apply_on && node_exp == 1 && stall_left > 0) begin
          apply_ready = 1'b0;
          stall_left--;
        end else begin
          apply_ready = 1'b1;
        end
        start = apply_on && !apply_ready;
      end else begin
        apply_ready = ($urandom_range(0, 2) != 0);
        start       = !finished && ($urandom_range(0, 5) == 0);
      end
      if (apply_on && apply_ready) begin
        node_exp++;
        if (node_exp == NODES) begin
          node_exp = 0;
          apply_on = 1'b0;
          last_hs  = cyc;
          iters_done++;
        end
      end
      if (!finished) tick();
    end
    start = 1'b0;
    if (!finished) check_val("run_timeout", 0, 1);
    check_val("n_next_iter", 32'(n_clear), 32'(exp_iters));
    check_val("n_scatter_start", 32'(n_ss), 32'(exp_iters));
    check_val("n_done", 32'(n_done), 1);
    check_val("final_count", 32'(iteration_count), 32'(exp_iters));
    check_val("run_wd_error", 32'(watchdog_error), 0);
    tick();
    scatter_operation_complete = 1'b0;
    gather_operation_complete  = 1'b0;
    check_val("after_busy", 32'(busy), 0);
    check_val("after_done", 32'(done), 0);
    check_val("count_hold", 32'(iteration_count), 32'(exp_iters));
    $display("run iters=%0d scatter_lat=%0d gather_lat=%0d mode=%0d cycles=%0d", n_iter, s_lat, g_lat, mode, cyc);
  endtask

  initial begin
    bit found;
    bit seen;
    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check_val("post_reset_busy", 32'(busy), 0);

    // Directed runs
    run(2, 5, 2, 0);   // two iterations, four handshakes each
    run(0, 3, 1, 0);   // zero target behaves as one
    run(3, 2, 1, 2);   // stall on node 1, start ignored while running
    run(1, 4, 0, 0);   // scatter and gather complete together: GATHER skipped
    run(2, 0, 0, 1);

    // Randomized runs
    for (int r = 0; r < 10; r++) begin
      run($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 4), 1);
    end

    // Reset mid-APPLY at node 2
    found = 1'b0;
    scatter_operation_complete = 1'b1;
    gather_operation_complete  = 1'b1;
    apply_ready    = 1'b1;
    num_iterations = ITER_W'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (apply_valid && apply_node_id == 32'd2) found = 1'b1;
      else tick();
    end
    check_val("rst_reached_node2", 32'(found), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_apply_reset");
    scatter_operation_complete = 1'b0;
    gather_operation_complete  = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check_all_zero("after_release");
    run(2, 1, 1, 0);
    $display("reset mid-apply then clean rerun");

    // Scatter completion never arrives
    scatter_operation_complete = 1'b0;
    gather_operation_complete  = 1'b0;
    num_iterations = ITER_W'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
`ifdef PAGERANK_WATCHDOG_EN
    for (int c = 0; c < 60 && !seen; c++) begin
      if (done) begin
        seen = 1'b1;
        check_val("wd_done_time", 32'(c), 32'(WD_CYCLES + 1));
        check_val("wd_error", 32'(watchdog_error), 1);
        check_val("wd_iter_count", 32'(iteration_count), 0);
      end else begin
        tick();
      end
    end
    check_val("wd_done_seen", 32'(seen), 1);
    tick();
    check_val("wd_sticky", 32'(watchdog_error), 1);
    check_val("wd_idle", 32'(busy), 0);
    run(1, 1, 1, 0);
    $display("watchdog expiry then clean rerun");
`else
    for (int c = 0; c < 40; c++) begin
      if (done) seen = 1'b1;
      check_val("hang_busy", 32'(busy), 1);
      tick();
    end
    check_val("hang_no_done", 32'(seen), 0);
    check_val("hang_wd_error", 32'(watchdog_error), 0);
    $display("scatter never completes: controller keeps waiting");
`endif
    reset_n = 1'b0;
    #1;
    check_all_zero("final_reset");
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
